// File: rtl/vga_char_pic.sv
// Text overlay for the VGA pixel stream: a 16-character line of 8x16 glyphs
// fetched from an external synchronous font ROM, with an optional blinking
// block cursor. pix_data trails pix_x/pix_y by exactly two vga_clk cycles.
module vga_char_pic #(
  parameter logic [9:0]  CHAR_X0      = 10'd256,
  parameter logic [9:0]  CHAR_Y0      = 10'd232,
  parameter logic [15:0] FG           = 16'hFFFF,
  parameter logic [15:0] BG           = 16'h0000,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [6:0]  wr_data,
  input  logic        cur_en,
  input  logic [3:0]  cur_pos
);

  localparam int            CW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);
  // 11-bit window limits so a window near the right/bottom edge cannot wrap
  localparam logic [10:0]   X_END      = {1'b0, CHAR_X0} + 11'd128;
  localparam logic [10:0]   Y_END      = {1'b0, CHAR_Y0} + 11'd16;

  logic [6:0]    text_buf [16];
  logic [6:0]    dx;
  logic [3:0]    dy;
  logic [3:0]    idx;
  logic [2:0]    col;
  logic          in_win;
  logic          cur_hit;
  logic          at_origin;
  logic          prev_origin;
  logic          frame_start;
  logic          in_win1;
  logic [2:0]    col1;
  logic          cur_hit1;
  logic [CW-1:0] blink_cnt;
  logic          blink_on;
  logic [2:0]    bit_sel;
  logic          glyph_bit;

  // Stage 0: window decode and font ROM address, all combinational
  assign dx  = 7'(pix_x - CHAR_X0);
  assign dy  = 4'(pix_y - CHAR_Y0);
  assign idx = dx[6:3];
  assign col = dx[2:0];

  assign in_win = (pix_x != 10'h3FF) && (pix_y != 10'h3FF) &&
                  (pix_x >= CHAR_X0) && ({1'b0, pix_x} < X_END) &&
                  (pix_y >= CHAR_Y0) && ({1'b0, pix_y} < Y_END);

  // The buffer read is combinational, so a same-cycle write to the displayed
  // entry is seen only from the following pixel onward.
  assign font_addr = in_win ? {text_buf[idx], dy} : 11'd0;
  assign cur_hit   = cur_en && (idx == cur_pos) && in_win;

  assign at_origin   = (pix_x == 10'd0) && (pix_y == 10'd0);
  assign frame_start = at_origin && !prev_origin;

  // Text buffer: cleared to spaces by reset, one write per cycle
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 16; i++) text_buf[i] <= 7'h20;
    end else if (wr_en) begin
      text_buf[wr_addr] <= wr_data;
    end
  end

  // Stage 1: pixel attributes registered alongside the ROM's address capture
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      in_win1     <= 1'b0;
      col1        <= 3'd0;
      cur_hit1    <= 1'b0;
      prev_origin <= 1'b0;
    end else begin
      in_win1     <= in_win;
      col1        <= col;
      cur_hit1    <= cur_hit;
      prev_origin <= at_origin;
    end
  end

  // Cursor blink: count frames, toggle phase after BLINK_FRAMES of them
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Glyph bit 7 is the leftmost pixel of the cell
  assign bit_sel   = 3'd7 - col1;
  assign glyph_bit = font_data[bit_sel];

  // Stage 2: colour the pixel; cursor inverts the glyph during the on phase
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_data <= BG;
    end else begin
      pix_data <= (in_win1 && (glyph_bit ^ (cur_hit1 & blink_on))) ? FG : BG;
    end
  end

endmodule
